// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath.
// It sequences fetch, decode, execute, memory and writeback, and drives every
// datapath enable and mux select plus the 2-bit ALUOP for the ALU control decoder.
// Optional feature macro: ILLEGAL_OP_TRAP_EN. When it is defined, an unknown
// opcode parks the FSM in TRAP with a sticky illegal_op flag. When it is not
// defined, an unknown opcode is executed as a NOP.
module multicycle_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2,
  parameter logic [5:0] OP_ADDI  = 6'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALUOP,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  logic       illegal_q;
  logic       op_known;

  assign op_known = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);

  // State register. Reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Opcode is latched in DECODE so that MEMADR ignores later changes to IR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 op_q <= '0;
    else if (state_q == DECODE) op_q <= opcode;
  end

`ifdef ILLEGAL_OP_TRAP_EN
  // Sticky illegal-opcode flag. It is set on entry to TRAP, so it is already
  // high during the first TRAP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                illegal_q <= 1'b0;
    else if (state_d == TRAP) illegal_q <= 1'b1;
  end
`else
  assign illegal_q = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = MEMADR;
        else if (opcode == OP_RTYPE)                state_d = EXEC;
        else if (opcode == OP_BEQ)                  state_d = BRANCH;
        else if (opcode == OP_J)                    state_d = JUMP;
        else if (opcode == OP_ADDI)                 state_d = ADDIEX;
        else begin
`ifdef ILLEGAL_OP_TRAP_EN
          state_d = TRAP;
`else
          state_d = FETCH;
`endif
        end
      end
      MEMADR: state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      JUMP:   state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Output decode. These are Moore outputs, except the mem_ready-qualified
  // strobes. Every output is gated low while reset is asserted.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ALUOP         = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    state         = '0;
    if (!reset) begin
      state      = state_q;
      illegal_op = illegal_q;
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b11;
`ifndef ILLEGAL_OP_TRAP_EN
          instr_done = ~op_known;
`endif
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          ALUOP     = 2'b10;
        end
        ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          ALUOP         = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath; directly upstream of the ALU control decoder.
- Decodes the instruction opcode and sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable/mux select plus the 2-bit ALUOP consumed by the ALU control decoder.
- Stalls on a memory ready handshake.

Parameters:
- OP_RTYPE, 6'd0, R-type opcode
- OP_LW, 6'd35, load word opcode
- OP_SW, 6'd43, store word opcode
- OP_BEQ, 6'd4, branch-equal opcode
- OP_J, 6'd2, jump opcode
- OP_ADDI, 6'd8, add-immediate opcode

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26]; sampled only in DECODE
- mem_ready  input  1  memory completes current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- iord  output  1  0 = PC addresses memory, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write enable
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- ALUOP  output  2  00 = add, 01 = sub (beq), 10 = use funct
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  output  1  sticky illegal-opcode flag
- state  output  4  current state (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12.
- State register updates on rising clk.
- reset asserted (any time, including mid-instruction):
  - state forced to FETCH immediately;
  - all outputs forced to 0, combinationally gated by reset;
  - illegal_op cleared.
- Outputs are Moore decodes of state. mem_ready-qualified exceptions: ir_write, pc_write in FETCH, and instr_done.
- Any output not listed for a state is 0.
- FETCH:
  - outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOP=00, pc_source=00;
  - ir_write = pc_write = mem_ready;
  - stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - outputs: alu_src_a=0, alu_src_b=11, ALUOP=00;
  - next state: LW/SW → MEMADR; RTYPE → EXEC; BEQ → BRANCH; J → JUMP; ADDI → ADDIEX; any other opcode → see Optional Feature.
- MEMADR:
  - outputs: alu_src_a=1, alu_src_b=10, ALUOP=00;
  - next state: LW → MEMRD, SW → MEMWR. The opcode is held in an internal register captured in DECODE; IR changes are ignored.
- MEMRD:
  - outputs: mem_read=1, iord=1;
  - stays until mem_ready=1, then goes to MEMWB.
- MEMWB:
  - outputs: reg_write=1, mem_to_reg=1, reg_dst=0;
  - next state FETCH.
- MEMWR:
  - outputs: mem_write=1, iord=1;
  - stays until mem_ready=1, then goes to FETCH.
- EXEC:
  - outputs: alu_src_a=1, alu_src_b=00, ALUOP=10;
  - next state ALUWB.
- ALUWB:
  - outputs: reg_write=1, reg_dst=1;
  - next state FETCH.
- BRANCH:
  - outputs: alu_src_a=1, alu_src_b=00, ALUOP=01, pc_write_cond=1, pc_source=01;
  - next state FETCH.
- ADDIEX:
  - outputs: alu_src_a=1, alu_src_b=10, ALUOP=00;
  - next state ADDIWB.
- ADDIWB:
  - outputs: reg_write=1, reg_dst=0;
  - next state FETCH.
- JUMP:
  - outputs: pc_write=1, pc_source=10;
  - next state FETCH.
- instr_done = 1 in: MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, MEMWR when mem_ready=1, and DECODE with an unknown opcode when the trap feature is compiled out.
- Latency with mem_ready held at 1 (cycles from FETCH entry): lw 5; sw, R-type, addi 4; beq, j 3.
- A wait of N cycles on mem_ready adds N cycles.
- mem_read and mem_write are never both 1.
- reg_write and ir_write are never both 1.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- With the macro defined:
  - an unknown opcode in DECODE goes to TRAP;
  - TRAP sets illegal_op=1 (sticky), drives all other outputs 0, and stays in TRAP until reset.
- Without the macro:
  - an unknown opcode is executed as a NOP: DECODE → FETCH with an instr_done pulse;
  - illegal_op is tied to 0;
  - TRAP state is unreachable.

Test Plan:
- Reset:
  - assert reset mid-MEMRD → state=0 and all outputs 0 in the same cycle;
  - deassert reset with mem_ready=1 → mem_read=1, ir_write=1, pc_write=1.
- R-type (opcode 0), mem_ready=1:
  - states 0,1,6,7,0;
  - ALUOP=10 in EXEC; reg_write=1 and reg_dst=1 in cycle 4; instr_done=1 in cycle 4 only.
- lw (opcode 35) with mem_ready low for 3 cycles in MEMRD:
  - mem_read=1 and iord=1 held 4 cycles;
  - MEMWB has reg_write=1, mem_to_reg=1; total 8 cycles.
- beq (opcode 4): BRANCH has ALUOP=01, pc_write_cond=1, pc_source=01; returns to FETCH after 3 cycles.
- j (opcode 2), then addi (opcode 8):
  - JUMP has pc_write=1, pc_source=10;
  - ADDIEX has alu_src_b=10, ALUOP=00; ADDIWB has reg_write=1, reg_dst=0.
- Opcode 63:
  - with ILLEGAL_OP_TRAP_EN → state=12, illegal_op=1, held until reset;
  - without the macro → instr_done pulse in DECODE, then FETCH.
